// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Holds the loader FSM state encoding, the 16-bit frame length type and the
// number of stream bytes that make up one instruction word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  typedef logic [15:0] len_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian byte-to-word assembler for the loader
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   i_shift      in   a data byte is accepted this cycle
//   i_byte       in   the byte being accepted
//   o_word       out  assembled word, valid when o_word_done is high
//   o_word_done  out  this accepted byte is the last byte of a word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  // Only the three earlier bytes need storing; the fourth is taken straight
  // from the input so the word can be registered by the top on the same edge.
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word      = {r_shift, i_byte};
  assign o_word_done = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream program loader with XOR checksum and cpu release
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_data    in   stream byte
//   in_valid   in   in_data is valid
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  one-cycle instruction-memory write strobe
//   mem_addr   out  byte address of the written word
//   mem_wdata  out  instruction word
//   cpu_run    out  program loaded and verified
//   done       out  frame accepted, checksum matched
//   error      out  frame rejected (bad length or checksum)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  state_t     r_state;
  logic       r_armed;
  len_t       r_len;
  len_t       r_word_cnt;
  logic [7:0] r_csum;

  logic        w_xfer;
  logic        w_shift;
  len_t        w_len;
  logic [31:0] w_word;
  logic        w_word_done;

  // r_armed holds in_ready low until the first edge after reset release.
  assign in_ready = r_armed && (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer   = in_valid && in_ready;
  assign w_shift  = w_xfer && (r_state == S_DATA);
  assign w_len    = {r_len[15:8], in_data};

  byte_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .i_shift     (w_shift),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_LEN_HI;
      r_armed    <= 1'b0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_run    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      mem_we  <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_LEN_HI: begin
            r_len[15:8] <= in_data;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len[7:0] <= in_data;
            if ((w_len == '0) || ({1'b0, w_len} > DEPTH)) begin
              error   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_csum <= r_csum ^ in_data;
            if (w_word_done) begin
              mem_we     <= 1'b1;
              mem_addr   <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
              mem_wdata  <= w_word;
              r_word_cnt <= r_word_cnt + 16'd1;
              if (r_word_cnt == r_len - 16'd1) begin
                r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (in_data == r_csum) begin
              done    <= 1'b1;
              cpu_run <= 1'b1;
              r_state <= S_DONE;
            end else begin
              error   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        rdy0, we0, run0, done0, err0;
  logic        rdy1, we1, run1, done1, err1;
  logic [31:0] addr0, data0, addr1, data1;

  imem_loader u_dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(data0),
    .cpu_run(run0), .done(done0), .error(err0)
  );

  imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0040_0000)) u_dut1 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(data1),
    .cpu_run(run1), .done(done1), .error(err1)
  );

  always #5 clock = ~clock;

  logic [1:0]  we_v, rdy_v, run_v, done_v, err_v;
  logic [31:0] addr_v [2];
  logic [31:0] data_v [2];
  assign we_v   = {we1, we0};
  assign rdy_v  = {rdy1, rdy0};
  assign run_v  = {run1, run0};
  assign done_v = {done1, done0};
  assign err_v  = {err1, err0};
  assign addr_v[0] = addr0;
  assign addr_v[1] = addr1;
  assign data_v[0] = data0;
  assign data_v[1] = data1;

  int          depth_v [2] = '{256, 16};
  logic [31:0] base_v  [2] = '{32'h0000_0000, 32'h0040_0000};

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   send_cyc [0:2047];
  exp_t sbq [$];
  int   fin_kind [2];
  int   fin_idx [2];
  bit   fin_seen [2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: derives expected writes and the final verdict directly
  // from the frame layout. fin_kind: 0 none, 1 done, 2 error.
  task automatic model(input bq_t f, input int d);
    int          n;
    int          b;
    logic [7:0]  x;
    logic [31:0] w;
    fin_kind[d] = 0;
    fin_idx[d]  = 0;
    fin_seen[d] = 1'b0;
    x = 8'h00;
    if (f.size() < 2) return;
    n = int'({f[0], f[1]});
    if (n == 0 || n > depth_v[d]) begin
      fin_kind[d] = 2;
      fin_idx[d]  = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      b = 2 + 4 * k;
      if (b + 3 < f.size()) begin
        w = {f[b], f[b+1], f[b+2], f[b+3]};
        sbq.push_back('{d, base_v[d] + 32'(4 * k), w, b + 3});
      end
    end
    for (int i = 2; i < 2 + 4 * n && i < f.size(); i++) x ^= f[i];
    if (f.size() > 2 + 4 * n) begin
      fin_kind[d] = (f[2 + 4 * n] == x) ? 1 : 2;
      fin_idx[d]  = 2 + 4 * n;
    end
  endtask

  always begin : monitor
    int j;
    @(negedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (we_v[d]) begin
        j = -1;
        for (int q = 0; q < sbq.size(); q++) if (j < 0 && sbq[q].d == d) j = q;
        if (j < 0) begin
          check($sformatf("dut%0d_unexpected_write", d), 32'd1, 32'd0);
        end else begin
          check($sformatf("dut%0d_wr_addr", d), addr_v[d], sbq[j].addr);
          check($sformatf("dut%0d_wr_data", d), data_v[d], sbq[j].data);
          check($sformatf("dut%0d_wr_cycle", d), cyc, send_cyc[sbq[j].idx]);
          sbq.delete(j);
        end
      end
      if (done_v[d] && !fin_seen[d]) begin
        fin_seen[d] = 1'b1;
        check($sformatf("dut%0d_done_kind", d), 32'd1, fin_kind[d]);
        check($sformatf("dut%0d_done_cycle", d), cyc, send_cyc[fin_idx[d]]);
      end
      if (err_v[d] && !fin_seen[d]) begin
        fin_seen[d] = 1'b1;
        check($sformatf("dut%0d_err_kind", d), 32'd2, fin_kind[d]);
        check($sformatf("dut%0d_err_cycle", d), cyc, send_cyc[fin_idx[d]]);
      end
    end
  end

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
  task automatic send_frame(input bq_t f, input int mode);
    int i;
    int pend;
    bit ph;
    bit go;
    i = 0;
    pend = -1;
    ph = 1'b1;
    while (i < f.size()) begin
      @(negedge clock);
      if (pend >= 0) send_cyc[pend] = cyc;
      pend = -1;
      go = (mode == 0) || (mode == 1 && ph) || (mode == 2 && $urandom_range(0, 3) != 0);
      ph = ~ph;
      if (go) begin
        in_valid = 1'b1;
        in_data  = f[i];
        pend = i;
        i++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clock);
    if (pend >= 0) send_cyc[pend] = cyc;
    in_valid = 1'b0;
  endtask

  task automatic end_checks(input int d);
    int cnt;
    cnt = 0;
    for (int q = 0; q < sbq.size(); q++) if (sbq[q].d == d) cnt++;
    check($sformatf("dut%0d_pending_writes", d), cnt, 0);
    check($sformatf("dut%0d_done", d), done_v[d], fin_kind[d] == 1);
    check($sformatf("dut%0d_cpu_run", d), run_v[d], fin_kind[d] == 1);
    check($sformatf("dut%0d_error", d), err_v[d], fin_kind[d] == 2);
    check($sformatf("dut%0d_in_ready", d), rdy_v[d], fin_kind[d] == 0);
    check($sformatf("dut%0d_verdict_seen", d), fin_seen[d], fin_kind[d] != 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_rst_in_ready", d), rdy_v[d], 0);
      check($sformatf("dut%0d_rst_mem_we", d), we_v[d], 0);
      check($sformatf("dut%0d_rst_mem_addr", d), addr_v[d], 0);
      check($sformatf("dut%0d_rst_mem_wdata", d), data_v[d], 0);
      check($sformatf("dut%0d_rst_cpu_run", d), run_v[d], 0);
      check($sformatf("dut%0d_rst_done", d), done_v[d], 0);
      check($sformatf("dut%0d_rst_error", d), err_v[d], 0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #2;
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d_ready_after_rst", d), rdy_v[d], 1);
  endtask

  task automatic run_frame(input bq_t f, input int mode);
    model(f, 0);
    model(f, 1);
    send_frame(f, mode);
    repeat (3) @(negedge clock);
    #2;
    end_checks(0);
    end_checks(1);
    do_reset();
  endtask

  task automatic mk(input int n, input bit bad, output bq_t f);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    f.delete();
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  initial begin : stim
    bq_t nom;
    bq_t f;
    bq_t part;
    nom = {8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h51};
    do_reset();

    run_frame(nom, 0);
    f = nom;
    f[10] = 8'h50;
    run_frame(f, 0);
    f = {8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame(f, 0);
    mk(257, 1'b0, f);
    run_frame(f, 0);
    mk(17, 1'b0, f);
    run_frame(f, 2);
    run_frame(nom, 1);

    part.delete();
    for (int i = 0; i < 6; i++) part.push_back(nom[i]);
    model(part, 0);
    model(part, 1);
    send_frame(part, 0);
    repeat (2) @(negedge clock);
    #2;
    end_checks(0);
    end_checks(1);
    do_reset();
    run_frame(nom, 0);

    mk(16, 1'b0, f);
    run_frame(f, 2);
    mk(256, 1'b0, f);
    run_frame(f, 0);

    for (int r = 0; r < 8; r++) begin
      mk($urandom_range(1, 20), 1'($urandom_range(0, 1)), f);
      run_frame(f, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
